// File: rtl/lch_gswarb_if.sv
// Cluster-to-switch arbiter bus: requester handshake plus switch-side output.
interface lch_gswarb_if #(
  parameter int unsigned NCL       = 4,
  parameter int unsigned CLDATWID  = 2,
  parameter int unsigned GSWDATWID = 3
);
  localparam int unsigned SRCWID = $clog2(NCL);

  logic [NCL-1:0]          cl_req_vld;
  logic [NCL*CLDATWID-1:0] cl_req_data;
  logic [NCL-1:0]          cl_req_rdy;
  logic                    gsw_rdy;
  logic                    lch_gswvld;
  logic [GSWDATWID-1:0]    lch_gswdata;
  logic [SRCWID-1:0]       lch_gswsrc;
  logic                    lch_stall;

  // Arbiter side
  modport master (
    input  cl_req_vld, cl_req_data, gsw_rdy,
    output cl_req_rdy, lch_gswvld, lch_gswdata, lch_gswsrc, lch_stall
  );

  // Requester/switch environment side
  modport slave (
    output cl_req_vld, cl_req_data, gsw_rdy,
    input  cl_req_rdy, lch_gswvld, lch_gswdata, lch_gswsrc, lch_stall
  );
endinterface

// File: rtl/lch_gswarb.sv
// Round-robin arbiter of NCL cluster requesters into a one-entry, parity-tagged
// switch output register, with a saturating back-pressure stall indicator.
module lch_gswarb #(
  parameter int unsigned NCL       = 4,
  parameter int unsigned CLDATWID  = 2,
  parameter int unsigned GSWDATWID = 3,
  parameter int unsigned STALLMAX  = 15
) (
  input  logic         clk,
  input  logic         reset_l,
  lch_gswarb_if.master bus
);

  localparam int unsigned PW = $clog2(NCL);
  localparam int unsigned CW = (STALLMAX > 0) ? $clog2(STALLMAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic                  vld_q;
  logic                  stall_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_nxt;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         src_q;
  logic [GSWDATWID-1:0]  data_q;

  logic [NCL-1:0]        gnt_oh;
  logic [PW-1:0]         gnt_idx;
  logic [CLDATWID-1:0]   gnt_word;
  logic [PW-1:0]         cand;
  logic                  found;
  logic                  load_en;
  logic                  acc;
  logic                  drain;

  assign load_en = ~vld_q | bus.gsw_rdy;
  assign bus.cl_req_rdy = gnt_oh & {NCL{load_en & reset_l}};
  assign acc     = |bus.cl_req_rdy;
  assign drain   = vld_q & bus.gsw_rdy;

  assign bus.lch_gswvld  = vld_q;
  assign bus.lch_gswdata = data_q;
  assign bus.lch_gswsrc  = src_q;
  assign bus.lch_stall   = stall_q;

  // Round-robin pick: first valid requester at or after ptr, wrapping mod NCL
  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_word = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NCL; k++) begin
      cand = ptr_q + PW'(k);
      if (!found && bus.cl_req_vld[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) gnt_oh[gnt_idx] = 1'b1;
    for (int unsigned i = 0; i < NCL; i++) begin
      if (gnt_oh[i]) gnt_word = bus.cl_req_data[i*CLDATWID +: CLDATWID];
    end
  end

  // Output-register occupancy FSM and stall counter next-state
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) state_nxt = SEND;
      end
      SEND, STALL: begin
        if (!bus.gsw_rdy) state_nxt = STALL;
        else if (acc)     state_nxt = SEND;
        else              state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (drain) begin
      cnt_nxt = '0;
    end else if (vld_q && !bus.gsw_rdy && (cnt_q != CW'(STALLMAX))) begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  // FSM, valid and stall flag registers
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      vld_q   <= (state_nxt != IDLE);
      cnt_q   <= cnt_nxt;
      stall_q <= (cnt_nxt == CW'(STALLMAX));
    end
  end

  // Output word, source index and round-robin pointer; held while not accepting
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      data_q <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else if (acc) begin
      data_q <= GSWDATWID'({gnt_word, ^gnt_word});
      src_q  <= gnt_idx;
      ptr_q  <= gnt_idx + PW'(1);
    end
  end

endmodule

// File: doc/lch_gswarb.md
LCH_GSWARB -- requirements
Module: lch_gswarb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  NCL, 4, number of cluster requesters (power of two, 2..8)
  CLDATWID, `COM_CLDATWID (2), per-cluster data width
  GSWDATWID, `LCH_GSWDATWID (3), switch data width; SHALL equal CLDATWID+1
  STALLMAX, 15, consecutive stall cycles before lch_stall asserts
REQ-002 Ports SHALL be (name direction width meaning):
  clk  input  1  sole clock, all state on rising edge
  reset_l  input  1  synchronous, active-low reset
  cl_req_vld  input  NCL  requester i offers a data word
  cl_req_data  input  NCL*CLDATWID  requester i word at [i*CLDATWID +: CLDATWID]
  cl_req_rdy  output  NCL  one-hot accept strobe to requester i
  gsw_rdy  input  1  switch accepts lch_gswdata this cycle
  lch_gswvld  output  1  lch_gswdata valid
  lch_gswdata  output  GSWDATWID  {cluster word, parity bit} to switch
  lch_gswsrc  output  log2(NCL)  index of cluster owning current word
  lch_stall  output  1  switch back-pressure exceeded STALLMAX
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low on reset_l.

Function
REQ-004 A requester transfer SHALL occur in a cycle where cl_req_vld[i] and cl_req_rdy[i] are both 1; a switch transfer where lch_gswvld and gsw_rdy are both 1.
REQ-005 Output register SHALL be one entry; load_en = !lch_gswvld | gsw_rdy.
REQ-006 cl_req_rdy SHALL be combinational: grant one-hot ANDed with load_en; zero when no cl_req_vld bit set or reset_l=0.
REQ-007 Grant SHALL be round-robin: highest priority at pointer ptr, descending through ptr+1, ptr+2 ... mod NCL.
REQ-008 After a transfer from requester i, ptr SHALL become (i+1) mod NCL next cycle; otherwise ptr SHALL hold.
REQ-009 On transfer from i, next cycle lch_gswvld=1, lch_gswsrc=i, lch_gswdata[GSWDATWID-1:1]=word, lch_gswdata[0]=XOR of word bits (even parity overall).
REQ-010 Latency SHALL be one cycle requester-accept to lch_gswvld; full throughput (one word/cycle) while gsw_rdy=1.
REQ-011 While lch_gswvld=1 and gsw_rdy=0, lch_gswdata and lch_gswsrc SHALL hold stable and cl_req_rdy SHALL be 0.
REQ-012 Simultaneous drain and load (gsw_rdy=1, new grant) SHALL replace the word with no bubble; drain without grant SHALL clear lch_gswvld next cycle; data/src then hold last value.
REQ-013 FSM states SHALL be IDLE (register empty), SEND (full, gsw_rdy=1 last cycle or just loaded), STALL (full, gsw_rdy=0); IDLE->SEND on load; SEND->STALL on gsw_rdy=0; STALL->SEND on gsw_rdy=1 with reload; SEND/STALL->IDLE on drain without reload.
REQ-014 Stall counter SHALL increment each STALL cycle, saturate at STALLMAX, clear on any switch transfer.
REQ-015 lch_stall SHALL be 1 when counter equals STALLMAX and clear the cycle after the switch transfer.
REQ-016 cl_req_data of non-granted requesters SHALL be ignored; cl_req_vld deassertion without transfer SHALL be legal.

Reset
REQ-017 With reset_l=0 at a clock edge, next cycle lch_gswvld=0, lch_gswdata=0, lch_gswsrc=0, lch_stall=0, ptr=0, stall counter=0, FSM=IDLE.
REQ-018 Reset mid-operation SHALL discard the held word without a switch transfer; cl_req_rdy SHALL be 0 during reset.
REQ-019 First grant after reset SHALL go to lowest-index valid requester.

Verification
REQ-020 All four valid, data 0,1,2,3, gsw_rdy=1 -> grants 0,1,2,3 on consecutive cycles; lch_gswdata 3'b000, 3'b011, 3'b101, 3'b110; src 0..3.
REQ-021 Requesters 1 and 3 always valid, gsw_rdy=1 -> grants alternate 1,3,1,3; no grant to 0 or 2.
REQ-022 Word loaded, gsw_rdy=0 for 20 cycles -> data/src stable, cl_req_rdy=0, lch_stall=1 from 15th stall cycle, clears cycle after gsw_rdy=1.
REQ-023 gsw_rdy toggles 1,0,1,0 with requester 2 valid (data 2'b10) -> exactly one accept per switch transfer, no loss or duplication.
REQ-024 reset_l=0 for one cycle while lch_gswvld=1 and stalled -> all outputs zero next cycle; next grant to lowest-index valid requester.
